// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg: opcode values, control-word layout and the opcode table decode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_ST   = 7'h01;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_SUB  = 7'h05;
  localparam logic [6:0] OP_AND  = 7'h08;
  localparam logic [6:0] OP_OR   = 7'h09;
  localparam logic [6:0] OP_XOR  = 7'h0A;
  localparam logic [6:0] OP_NOT  = 7'h0B;
  localparam logic [6:0] OP_LD   = 7'h21;
  localparam logic [6:0] OP_ADI  = 7'h22;
  localparam logic [6:0] OP_MOVA = 7'h40;
  localparam logic [6:0] OP_BZ   = 7'h60;
  localparam logic [6:0] OP_JMP  = 7'h70;

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
    logic       ma;
    logic       mb;
    logic       cs;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  uses_a;
    logic  uses_b;
    logic  illegal;
  } dec_t;

  // Opcode arrives zero-extended to 32 bits so any OPC_W up to 32 decodes
  // correctly: set upper bits simply fail every table entry.
  function automatic dec_t decode_op(input logic [31:0] opc);
    dec_t d;
    d        = '0;
    d.uses_a = 1'b1;
    case (opc)
      32'(OP_NOP):  d.uses_a = 1'b0;
      32'(OP_ADD):  begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'h02; d.uses_b = 1'b1; end
      32'(OP_SUB):  begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'h05; d.uses_b = 1'b1; end
      32'(OP_AND):  begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'h08; d.uses_b = 1'b1; end
      32'(OP_OR):   begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'h09; d.uses_b = 1'b1; end
      32'(OP_XOR):  begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'h0A; d.uses_b = 1'b1; end
      32'(OP_NOT):  begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'h0B; end
      32'(OP_MOVA): d.ctrl.rw = 1'b1;
      32'(OP_LD):   begin d.ctrl.rw = 1'b1; d.ctrl.md = 2'b01; end
      32'(OP_ST):   begin d.ctrl.mw = 1'b1; d.uses_b = 1'b1; end
      32'(OP_ADI):  begin d.ctrl.rw = 1'b1; d.ctrl.mb = 1'b1; d.ctrl.fs = 5'h02; end
      32'(OP_BZ):   begin
        d.ctrl.bs = 2'b01; d.ctrl.ps = 1'b1; d.ctrl.mb = 1'b1; d.ctrl.cs = 1'b1;
      end
      32'(OP_JMP):  d.ctrl.bs = 2'b10;
      default:      begin d.uses_a = 1'b0; d.illegal = 1'b1; end
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_scoreboard.sv
// ---------------------------------------------------------------------------
// decode_scoreboard: per-register pending-write bits with three lookup ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_AW-1:0] d_addr,
  output logic              a_pend,
  output logic              b_pend,
  output logic              d_pend
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0] pend;

  // Set is written after clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      if (set_en) pend[set_addr] <= 1'b1;
    end
  end

  assign a_pend = pend[a_addr];
  assign b_pend = pend[b_addr];
  assign d_pend = pend[d_addr];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage: registered IR decode with RAW/WAW stall, branch wait, flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int OPC_W  = 7,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rw,
  output logic              mw,
  output logic              ps,
  output logic              ma,
  output logic              mb,
  output logic              cs,
  output logic [1:0]        md,
  output logic [1:0]        bs,
  output logic [4:0]        fs,
  output logic [REG_AW-1:0] da,
  output logic [REG_AW-1:0] aa,
  output logic [REG_AW-1:0] ba,
  output logic [IR_W-1:0]   imm,
  output logic              illegal,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic              br_resolve,
  input  logic              flush
);

  localparam int FIELD_LSB = IR_W - OPC_W - 3*REG_AW;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] dr, sa, sb;
  logic [31:0]       opc_ext;
  dec_t              dec;
  logic [IR_W-1:0]   imm_next;
  logic              pend_a, pend_b, pend_d;
  logic              hz, accept;
  logic [0:0]        state;
  ctrl_t             ctrl;

  assign opc     = ir[IR_W-1 -: OPC_W];
  assign dr      = ir[IR_W-OPC_W-1 -: REG_AW];
  assign sa      = ir[IR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign sb      = ir[FIELD_LSB +: REG_AW];
  assign opc_ext = 32'(opc);
  assign dec     = decode_op(opc_ext);

  generate
    if (FIELD_LSB > 0) begin : g_unused_low
      logic unused_low_bits;
      assign unused_low_bits = ^ir[FIELD_LSB-1:0];
    end
  endgenerate

  assign imm_next = dec.ctrl.cs ? {{(IR_W-REG_AW){sb[REG_AW-1]}}, sb}
                                : {{(IR_W-REG_AW){1'b0}}, sb};

  decode_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept & dec.ctrl.rw),
    .set_addr (dr),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .a_addr   (sa),
    .b_addr   (sb),
    .d_addr   (dr),
    .a_pend   (pend_a),
    .b_pend   (pend_b),
    .d_pend   (pend_d)
  );

  // Registered pend only: a writeback in this cycle does not release a stall
  // until the next one.
  assign hz = (dec.uses_a & pend_a) | (dec.uses_b & pend_b) | (dec.ctrl.rw & pend_d);

  assign in_ready = (state == ST_RUN) & ~hz & (~out_valid | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (flush) begin
      state <= ST_RUN;
    end else if (state == ST_RUN) begin
      if (accept && dec.ctrl.bs != 2'b00) state <= ST_BR_WAIT;
    end else if (br_resolve) begin
      state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      da        <= '0;
      aa        <= '0;
      ba        <= '0;
      imm       <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl      <= dec.ctrl;
      da        <= dr;
      aa        <= sa;
      ba        <= sb;
      imm       <= imm_next;
      illegal   <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rw = ctrl.rw;
  assign md = ctrl.md;
  assign bs = ctrl.bs;
  assign ps = ctrl.ps;
  assign mw = ctrl.mw;
  assign fs = ctrl.fs;
  assign ma = ctrl.ma;
  assign mb = ctrl.mb;
  assign cs = ctrl.cs;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage: directed plus random stimulus against a behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        rw, mw, ps, ma, mb, cs, illegal, wb_valid, br_resolve, flush;
  logic [1:0]  md, bs;
  logic [4:0]  fs, da, aa, ba, wb_addr;
  logic [31:0] ir, imm;

  always #5 clk = ~clk;

  decode_stage #(.IR_W(32), .OPC_W(7), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .out_valid(out_valid), .out_ready(out_ready),
    .rw(rw), .mw(mw), .ps(ps), .ma(ma), .mb(mb), .cs(cs), .md(md), .bs(bs),
    .fs(fs), .da(da), .aa(aa), .ba(ba), .imm(imm), .illegal(illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .br_resolve(br_resolve), .flush(flush)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [6:0] opc;
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
    logic       mb;
    logic       cs;
    logic       ub;
  } row_t;

  row_t tbl[13];

  function automatic row_t row(input logic [6:0] o, input logic w, input logic [1:0] m,
                               input logic [1:0] b, input logic p, input logic memw,
                               input logic [4:0] f, input logic imb, input logic c,
                               input logic u);
    row_t r;
    r = '{opc:o, rw:w, md:m, bs:b, ps:p, mw:memw, fs:f, mb:imb, cs:c, ub:u};
    return r;
  endfunction

  initial begin
    tbl[0]  = row(7'h00, 0, 2'b00, 2'b00, 0, 0, 5'h00, 0, 0, 0);
    tbl[1]  = row(7'h02, 1, 2'b00, 2'b00, 0, 0, 5'h02, 0, 0, 1);
    tbl[2]  = row(7'h05, 1, 2'b00, 2'b00, 0, 0, 5'h05, 0, 0, 1);
    tbl[3]  = row(7'h08, 1, 2'b00, 2'b00, 0, 0, 5'h08, 0, 0, 1);
    tbl[4]  = row(7'h09, 1, 2'b00, 2'b00, 0, 0, 5'h09, 0, 0, 1);
    tbl[5]  = row(7'h0A, 1, 2'b00, 2'b00, 0, 0, 5'h0A, 0, 0, 1);
    tbl[6]  = row(7'h0B, 1, 2'b00, 2'b00, 0, 0, 5'h0B, 0, 0, 0);
    tbl[7]  = row(7'h40, 1, 2'b00, 2'b00, 0, 0, 5'h00, 0, 0, 0);
    tbl[8]  = row(7'h21, 1, 2'b01, 2'b00, 0, 0, 5'h00, 0, 0, 0);
    tbl[9]  = row(7'h01, 0, 2'b00, 2'b00, 0, 1, 5'h00, 0, 0, 1);
    tbl[10] = row(7'h22, 1, 2'b00, 2'b00, 0, 0, 5'h02, 1, 0, 0);
    tbl[11] = row(7'h60, 0, 2'b00, 2'b01, 1, 0, 5'h00, 1, 1, 0);
    tbl[12] = row(7'h70, 0, 2'b00, 2'b10, 0, 0, 5'h00, 0, 0, 0);
  end

  // Reference state: pending registers, branch-wait flag, expected output word.
  bit          pend[32];
  bit          br_wait;
  bit          m_ov;
  row_t        m_row;
  logic        m_ill;
  logic [4:0]  m_da, m_aa, m_ba;
  logic [31:0] m_imm;

  function automatic logic [31:0] mk(input logic [6:0] o, input logic [4:0] d,
                                     input logic [4:0] a, input logic [4:0] b);
    return {o, d, a, b, 10'h0};
  endfunction

  task automatic lookup(input logic [6:0] o, output row_t r, output bit legal);
    r = '0;
    legal = 0;
    foreach (tbl[i]) if (tbl[i].opc == o) begin r = tbl[i]; legal = 1; end
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("rw", rw, m_row.rw);
    check("md", md, m_row.md);
    check("bs", bs, m_row.bs);
    check("ps", ps, m_row.ps);
    check("mw", mw, m_row.mw);
    check("fs", fs, m_row.fs);
    check("ma", ma, 1'b0);
    check("mb", mb, m_row.mb);
    check("cs", cs, m_row.cs);
    check("da", da, m_da);
    check("aa", aa, m_aa);
    check("ba", ba, m_ba);
    check("imm", imm, m_imm);
    check("illegal", illegal, m_ill);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; ir = '0; out_ready = 0; wb_valid = 0; wb_addr = '0;
    br_resolve = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    foreach (pend[i]) pend[i] = 0;
    br_wait = 0; m_ov = 0; m_row = '0; m_ill = 0;
    m_da = '0; m_aa = '0; m_ba = '0; m_imm = '0;
    check_outputs();
  endtask

  task automatic step(input bit iv, input logic [31:0] w, input bit ordy, input bit wbv,
                      input logic [4:0] wba, input bit brr, input bit fl);
    row_t r;
    bit legal, hz, rdy, acc;
    logic [6:0] o;
    logic [4:0] d, a, b;
    in_valid = iv; ir = w; out_ready = ordy; wb_valid = wbv; wb_addr = wba;
    br_resolve = brr; flush = fl;
    o = w[31:25]; d = w[24:20]; a = w[19:15]; b = w[14:10];
    lookup(o, r, legal);
    hz  = (legal && o != 7'h00 && pend[a]) || (r.ub && pend[b]) || (r.rw && pend[d]);
    rdy = !br_wait && !hz && (!m_ov || ordy) && !fl;
    #1 check("in_ready", in_ready, rdy);
    acc = iv && rdy;
    @(posedge clk);
    if (fl) begin
      m_ov = 0;
      br_wait = 0;
    end else if (acc) begin
      m_ov = 1; m_row = r; m_ill = !legal;
      m_da = d; m_aa = a; m_ba = b;
      m_imm = (r.cs && b[4]) ? (32'hFFFF_FFE0 | 32'(b)) : 32'(b);
      if (r.bs != 0) br_wait = 1;
    end else begin
      if (ordy) m_ov = 0;
      if (br_wait && brr) br_wait = 0;
    end
    if (wbv) pend[wba] = 0;
    if (acc && r.rw) pend[d] = 1;
    #1 check_outputs();
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  o;
    int          sel;

    do_reset();

    // ADD R1,R2,R3 then dependent SUB R4,R1,R3
    step(1, mk(7'h02, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 0);
    check("t1_fs", fs, 5'b00010);
    check("t1_da", da, 5'd1);
    step(1, mk(7'h05, 5'd4, 5'd1, 5'd3), 1, 0, 0, 0, 0);
    step(1, mk(7'h05, 5'd4, 5'd1, 5'd3), 1, 1, 5'd1, 0, 0);
    step(1, mk(7'h05, 5'd4, 5'd1, 5'd3), 1, 0, 0, 0, 0);
    check("t2_fs", fs, 5'b00101);
    check("t2_da", da, 5'd4);
    step(0, '0, 1, 1, 5'd4, 0, 0);

    // Immediate extension and branch wait
    step(1, mk(7'h22, 5'd5, 5'd0, 5'h1F), 1, 1, 5'd5, 0, 0);
    check("t3_imm_zx", imm, 32'h0000_001F);
    step(1, mk(7'h60, 5'd0, 5'd6, 5'h1F), 1, 1, 5'd5, 0, 0);
    check("t3_imm_sx", imm, 32'hFFFF_FFFF);
    step(1, mk(7'h02, 5'd9, 5'd10, 5'd11), 1, 0, 0, 0, 0);
    step(1, mk(7'h02, 5'd9, 5'd10, 5'd11), 1, 0, 0, 1, 0);
    step(1, mk(7'h02, 5'd9, 5'd10, 5'd11), 1, 1, 5'd9, 0, 0);
    step(0, '0, 1, 1, 5'd9, 0, 0);

    // Illegal opcode
    step(1, mk(7'h7F, 5'd12, 5'd13, 5'd14), 1, 0, 0, 0, 0);
    check("t4_illegal", illegal, 1'b1);

    // Back-pressure, flush, and WAW on R7 with same-cycle set/clear
    step(1, mk(7'h02, 5'd7, 5'd8, 5'd8), 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, mk(7'h09, 5'd20, 5'd21, 5'd22), 0, 0, 0, 0, 0);
    step(1, mk(7'h09, 5'd20, 5'd21, 5'd22), 0, 0, 0, 0, 1);
    step(1, mk(7'h02, 5'd7, 5'd1, 5'd2), 1, 0, 0, 0, 0);
    step(1, mk(7'h02, 5'd7, 5'd1, 5'd2), 1, 1, 5'd7, 0, 0);
    step(1, mk(7'h02, 5'd7, 5'd1, 5'd2), 1, 1, 5'd7, 0, 0);
    step(1, mk(7'h02, 5'd7, 5'd1, 5'd2), 1, 0, 0, 0, 0);
    check("t6_waw_stall", in_ready, 1'b0);

    // Reset in the middle of activity
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 15);
      if (sel < 13)       o = tbl[sel].opc;
      else if (sel == 13) o = 7'h7F;
      else                o = 7'($urandom);
      w = {o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom)};
      w[14] = 1'($urandom);
      step($urandom_range(0, 9) < 8, w, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
      if (n == 1500) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised instruction-decode stage for the RISC datapath; successor to the combinational decoder.
- Accepts IR words over a valid/ready handshake and emits a registered control word: RW, DA, MD, BS, PS, MW, FS, MA, MB, CS, AA, BA, plus an extended immediate.
- Adds a register scoreboard for RAW/WAW stalls, a branch-wait state machine, an illegal-opcode flag and flush.

Parameters:
- IR_W, 32, instruction width.
- OPC_W, 7, opcode field width.
- REG_AW, 5, register address width; NREG = 2**REG_AW.
- Constraint: IR_W >= OPC_W + 3*REG_AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  IR valid.
- in_ready  out  1  stage can accept IR this cycle.
- ir  in  IR_W  instruction. Fields, MSB first: OPC, DR, SA, SB, then unused low bits.
- out_valid  out  1  control word valid.
- out_ready  in  1  execute stage accepts control word.
- rw, mw, ps, ma, mb, cs  out  1 each  control bits.
- md, bs  out  2 each  control fields.
- fs  out  5  function select.
- da, aa, ba  out  REG_AW each  register addresses (DR, SA, SB).
- imm  out  IR_W  SB field: zero-extended if cs=0, sign-extended if cs=1.
- illegal  out  1  opcode not in table (controls forced to NOP).
- wb_valid  in  1  writeback completes.
- wb_addr  in  REG_AW  register being written back.
- br_resolve  in  1  branch outcome resolved; pulse.
- flush  in  1  discard held control word.

Behaviour:
- Reset: all outputs 0, out_valid=0, scoreboard all clear, FSM=RUN.
- Opcode table (hex opcode: nonzero controls; unlisted controls are 0):
  - 00 NOP: none.
  - 02 ADD: RW, FS=02.
  - 05 SUB: RW, FS=05.
  - 08 AND: RW, FS=08.
  - 09 OR: RW, FS=09.
  - 0A XOR: RW, FS=0A.
  - 0B NOT: RW, FS=0B.
  - 40 MOVA: RW, FS=00.
  - 21 LD: RW, MD=01.
  - 01 ST: MW.
  - 22 ADI: RW, MB, FS=02.
  - 60 BZ: BS=01, PS, MB, CS.
  - 70 JMP: BS=10.
  - Any other opcode: NOP controls with illegal=1.
- Register usage:
  - uses_a: every legal opcode except NOP.
  - uses_b: ADD, SUB, AND, OR, XOR, ST.
  - writes: RW=1.
- Hazard: hz = (uses_a & pend[SA]) | (uses_b & pend[SB]) | (writes & pend[DR]). Uses registered pend only; no same-cycle wb bypass.
- in_ready = (FSM==RUN) & !hz & (!out_valid | out_ready).
- Latency: accept when in_valid & in_ready; control word is registered and out_valid=1 the next cycle. Throughput is 1 instruction/cycle when there is no hazard.
- Output register holds stable while out_valid & !out_ready.
- Scoreboard:
  - On accept with writes: pend[DR] <= 1.
  - On wb_valid: pend[wb_addr] <= 0.
  - Set and clear of the same index in one cycle: set wins.
  - wb_valid to a non-pending register: no effect.
- FSM:
  - RUN to BR_WAIT on accept of an instruction with BS != 0.
  - BR_WAIT to RUN on br_resolve; the stage accepts again in the following cycle.
  - br_resolve in RUN is ignored.
- flush:
  - out_valid <= 0 and FSM <= RUN; scoreboard unchanged.
  - The flushed control word's pend bit stays set; execute must still write back or the stage stays stalled.
  - flush and accept in the same cycle: flush wins and the input is not consumed, so in_ready is gated by !flush.
- rst mid-operation: identical to reset; scoreboard cleared and any pending word dropped.

Decomposition:
- Package decode_pkg holds:
  - Opcode localparams.
  - Control-word struct/typedef (rw, md, bs, ps, mw, fs, ma, mb, cs).
  - Function decode_op(opcode) returning the control word plus uses_a, uses_b, illegal.
- One sub-module, decode_scoreboard (NREG pend bits, set/clear ports, three lookup ports).
- Table decode and FSM stay in the top module.

Test Plan:
1. Reset, then ir=0000010_00001_00010_00011_0..0 (ADD R1,R2,R3), out_ready=1 -> next cycle out_valid=1, rw=1, fs=00010, da=1, aa=2, ba=3, illegal=0.
2. ADD R1,R2,R3 then SUB R4,R1,R3 back-to-back -> SUB stalls (in_ready=0) until wb_valid with wb_addr=1. SUB issues the cycle after wb; rw=1, fs=00101, da=4.
3. ADI R5,R0,imm SB=5'b11111 -> imm=0x0000001F, mb=1. BZ with SB=5'b11111 -> cs=1, imm=0xFFFFFFFF, bs=01, ps=1; in_ready=0 until br_resolve, then 1 one cycle later.
4. opcode 7'h7F -> illegal=1, rw=0, mw=0, bs=00; scoreboard unchanged.
5. out_ready=0 with out_valid=1 for 3 cycles -> outputs stable, in_ready=0. Then flush=1 -> out_valid=0 next cycle; pend[DR] still 1.
6. Two writes to R7 in flight: second ADD R7 stalls (WAW) until wb_addr=7. Same cycle wb_valid(R7) and accept of a new write to R7 -> pend[7]=1 afterwards.
